mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one single-port memory bus between the pipelined CPU's instruction-fetch port and data port.
//  Serialises the two requests and issues exactly one bus transaction at a time.
//  Returns read data with a one-cycle ack pulse, and drives cpu_stall while any CPU request is unserved.
//  Sits between the datapath memory ports and the memory/bus wrapper.
// PARAMETERS
//  TIMEOUT_CYCLES  64  bus cycles waited for bus_ack before the transaction is aborted (>=2)
//  FAIR_LIMIT      4   consecutive data grants allowed while inst is pending before inst is forced (>=1)
// PORTS
//  clk          in   1   single clock, rising edge
//  cpu_rst_n    in   1   asynchronous active-low reset
//  inst_ren     in   1   fetch request; held stable with inst_addr until inst_ack
//  inst_addr    in   32  fetch address
//  inst_data    out  32  fetched word (registered; valid in inst_ack cycle, held after)
//  inst_ack     out  1   1-cycle pulse: fetch complete
//  mem_ren      in   1   data read request; held stable with mem_addr until mem_ack
//  mem_wen      in   1   data write request; held stable with mem_addr/mem_dout until mem_ack
//  mem_addr     in   32  data address
//  mem_dout     in   32  write data from CPU
//  mem_din      out  32  read data to CPU (registered; valid in mem_ack cycle, held after)
//  mem_ack      out  1   1-cycle pulse: data access complete
//  cpu_stall    out  1   (inst_ren & ~inst_ack) | ((mem_ren|mem_wen) & ~mem_ack), combinational
//  bus_req      out  1   bus transaction active
//  bus_we       out  1   1 = write
//  bus_addr     out  32  bus address
//  bus_wdata    out  32  bus write data
//  bus_rdata    in   32  bus read data, valid with bus_ack
//  bus_ack      in   1   bus completes transaction this cycle
//  bus_err      out  1   1-cycle pulse, asserted with the ack of a timed-out or misaligned access
// BEHAVIOUR
//  - Reset: all registered outputs are 0 (bus_req/bus_we/bus_addr/bus_wdata, both acks,
//    inst_data, mem_din, bus_err), state IDLE, counters 0.
//    Assertion mid-transaction drops bus_req immediately.
//  - FSM states: IDLE, INST, DATA, DONE. All bus_* outputs are registered.
//  - IDLE: a requester whose ack is high this cycle is ignored, preventing a double grant.
//    Data request (ren|wen) wins over inst, except when the fair counter == FAIR_LIMIT and inst is pending.
//    Grant latches address/we/wdata into bus_* regs and sets bus_req at the next edge (-> INST or DATA).
//    mem_ren & mem_wen together = write.
//  - Misaligned data address (mem_addr[1:0]!=0): no bus transaction; IDLE -> DONE.
//    mem_ack and bus_err pulse; mem_din = 0. Inst addresses are never checked.
//  - INST/DATA: bus_* held stable until bus_ack.
//    On the bus_ack cycle the next edge clears bus_req, captures bus_rdata
//    (inst_data for INST, mem_din for DATA reads; writes leave mem_din unchanged), pulses the ack, and enters DONE.
//  - Timeout: the counter increments each cycle in INST/DATA with bus_ack low.
//    When it reaches TIMEOUT_CYCLES-1 with no ack, the transaction is aborted exactly as an ack.
//    Captured data = 32'h0 and bus_err pulses. The counter clears on every grant.
//  - DONE lasts one cycle (ack cycle), then -> IDLE.
//    Minimum latency: request seen in cycle 0, bus_req in cycle 1; with bus_ack in cycle 1, ack in cycle 2.
//  - Fair counter: increments on each data grant while inst_ren is high, and clears on each inst grant.
//    It saturates at FAIR_LIMIT.
//  - Requests dropped without ack (CPU flush): an in-flight bus transaction still completes.
//    The ack pulse is still generated, and the CPU ignores it.
// TESTING
//  1 Reset, inst_ren=1 addr 0x0, bus_ack after 1 cycle, rdata 0x20080005 -> inst_ack in cycle 2, inst_data=0x20080005, bus_err=0
//  2 inst_ren and mem_ren(addr 0x40) asserted together -> data granted first, then inst; cpu_stall high until second ack
//  3 mem_wen addr 0x44 dout 0xDEADBEEF -> bus_we=1, bus_wdata=0xDEADBEEF, mem_din unchanged after mem_ack
//  4 mem_ren addr 0x42 -> no bus_req, mem_ack and bus_err pulse together, mem_din=0
//  5 bus_ack never asserted -> abort after 64 cycles, mem_ack+bus_err, data 0, FSM back to IDLE
//  6 continuous data requests with inst_ren held -> inst granted after exactly 4 data grants; cpu_rst_n low mid-INST -> bus_req=0 immediately

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbiter that serialises CPU instruction-fetch and data accesses onto one single-port memory bus.
// Data wins by default. Instruction fetch is forced after FAIR_LIMIT data grants. Stuck transactions are aborted after TIMEOUT_CYCLES.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned FAIR_LIMIT     = 4
) (
  input  logic        clk,
  input  logic        cpu_rst_n,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  output logic        inst_ack,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_ack,
  output logic        cpu_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned FAIR_W = $clog2(FAIR_LIMIT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FAIR_W-1:0] FAIR_MAX = FAIR_W'(FAIR_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e             state_q,     state_d;
  logic               bus_req_q,   bus_req_d;
  logic               bus_we_q,    bus_we_d;
  logic [31:0]        bus_addr_q,  bus_addr_d;
  logic [31:0]        bus_wdata_q, bus_wdata_d;
  logic               bus_err_q,   bus_err_d;
  logic               inst_ack_q,  inst_ack_d;
  logic               mem_ack_q,   mem_ack_d;
  logic [31:0]        inst_data_q, inst_data_d;
  logic [31:0]        mem_din_q,   mem_din_d;
  logic [TMO_W-1:0]   tmo_cnt_q,   tmo_cnt_d;
  logic [FAIR_W-1:0]  fair_cnt_q,  fair_cnt_d;

  logic        inst_pend_c;
  logic        data_pend_c;
  logic        force_inst_c;
  logic        misaligned_c;
  logic        finish_c;
  logic        timed_out_c;
  logic [31:0] cap_data_c;

  // A requester whose ack is visible this cycle is already served; do not grant it again.
  always_comb begin
    inst_pend_c  = inst_ren & ~inst_ack_q;
    data_pend_c  = (mem_ren | mem_wen) & ~mem_ack_q;
    force_inst_c = inst_pend_c & (fair_cnt_q == FAIR_MAX);
    misaligned_c = mem_addr[1:0] != 2'b00;
    timed_out_c  = ~bus_ack & (tmo_cnt_q == TMO_LAST);
    finish_c     = bus_ack | timed_out_c;
    cap_data_c   = bus_ack ? bus_rdata : 32'h0;
  end

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_err_d   = 1'b0;
    inst_ack_d  = 1'b0;
    mem_ack_d   = 1'b0;
    inst_data_d = inst_data_q;
    mem_din_d   = mem_din_q;
    tmo_cnt_d   = tmo_cnt_q;
    fair_cnt_d  = fair_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (data_pend_c && !force_inst_c) begin
          if (inst_ren && (fair_cnt_q != FAIR_MAX)) begin
            fair_cnt_d = fair_cnt_q + FAIR_W'(1);
          end
          tmo_cnt_d = '0;
          // Misaligned data access is answered locally with an error, never reaching the bus.
          if (misaligned_c) begin
            mem_ack_d = 1'b1;
            bus_err_d = 1'b1;
            mem_din_d = 32'h0;
            state_d   = DONE;
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = mem_wen;
            bus_addr_d  = mem_addr;
            bus_wdata_d = mem_dout;
            state_d     = DATA;
          end
        end else if (inst_pend_c) begin
          fair_cnt_d  = '0;
          tmo_cnt_d   = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = inst_addr;
          bus_wdata_d = 32'h0;
          state_d     = INST;
        end
      end

      INST: begin
        if (finish_c) begin
          bus_req_d   = 1'b0;
          inst_ack_d  = 1'b1;
          bus_err_d   = timed_out_c;
          inst_data_d = cap_data_c;
          state_d     = DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      DATA: begin
        if (finish_c) begin
          bus_req_d = 1'b0;
          mem_ack_d = 1'b1;
          bus_err_d = timed_out_c;
          if (!bus_we_q) begin
            mem_din_d = cap_data_c;
          end
          state_d = DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_err_q   <= 1'b0;
      inst_ack_q  <= 1'b0;
      mem_ack_q   <= 1'b0;
      inst_data_q <= 32'h0;
      mem_din_q   <= 32'h0;
      tmo_cnt_q   <= '0;
      fair_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_err_q   <= bus_err_d;
      inst_ack_q  <= inst_ack_d;
      mem_ack_q   <= mem_ack_d;
      inst_data_q <= inst_data_d;
      mem_din_q   <= mem_din_d;
      tmo_cnt_q   <= tmo_cnt_d;
      fair_cnt_q  <= fair_cnt_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_err   = bus_err_q;
  assign inst_ack  = inst_ack_q;
  assign mem_ack   = mem_ack_q;
  assign inst_data = inst_data_q;
  assign mem_din   = mem_din_q;

  // Stall is combinational so the pipeline freezes in the same cycle a request appears.
  assign cpu_stall = (inst_ren & ~inst_ack_q) | ((mem_ren | mem_wen) & ~mem_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, priority, write, misalignment, timeout, fairness and async reset.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        cpu_rst_n;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_ack;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_ack;
  logic        cpu_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  int n_err = 0;
  int n_chk = 0;

  // Memory responder controls: acks in the first bus_req cycle unless disabled or the address is blocked.
  logic        auto_ack  = 1'b1;
  logic [31:0] noack_addr = 32'hFFFF_FFFF;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(64), .FAIR_LIMIT(4)) dut (
    .clk(clk), .cpu_rst_n(cpu_rst_n),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data), .inst_ack(inst_ack),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ack(mem_ack), .cpu_stall(cpu_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return 32'h2008_0005 ^ (a << 8);
  endfunction

  initial begin
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (auto_ack && bus_req && (bus_addr != noack_addr)) begin
        bus_ack   = 1'b1;
        bus_rdata = rdata_of(bus_addr);
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cpu_rst_n = 1'b0;
    inst_ren = 1'b0; inst_addr = 32'h0;
    mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = 32'h0; mem_dout = 32'h0;
    repeat (3) tick();
    n_chk++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL reset_bus_req got %b exp 0", bus_req); end
    n_chk++; if ({bus_we, bus_err, inst_ack, mem_ack} !== 4'b0) begin n_err++; $display("FAIL reset_flags got %b exp 0000", {bus_we, bus_err, inst_ack, mem_ack}); end
    n_chk++; if ({bus_addr, bus_wdata, inst_data, mem_din} !== 128'h0) begin n_err++; $display("FAIL reset_data got %h exp 0", {bus_addr, bus_wdata, inst_data, mem_din}); end
    n_chk++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", cpu_stall); end
    @(negedge clk);
    cpu_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_inst_fetch();
    inst_ren = 1'b1; inst_addr = 32'h0;
    #1;
    n_chk++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall0 got %b exp 1", cpu_stall); end
    tick();
    n_chk++; if ({bus_req, bus_we, bus_addr} !== {1'b1, 1'b0, 32'h0}) begin n_err++; $display("FAIL fetch_bus got %b%b %h exp 1 0 00000000", bus_req, bus_we, bus_addr); end
    n_chk++; if (inst_ack !== 1'b0) begin n_err++; $display("FAIL fetch_ack_early got %b exp 0", inst_ack); end
    tick();
    n_chk++; if ({inst_ack, bus_err, bus_req} !== 3'b100) begin n_err++; $display("FAIL fetch_ack got %b exp 100", {inst_ack, bus_err, bus_req}); end
    n_chk++; if (inst_data !== 32'h2008_0005) begin n_err++; $display("FAIL fetch_data got %h exp 20080005", inst_data); end
    n_chk++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL fetch_stall_ack got %b exp 0", cpu_stall); end
    inst_ren = 1'b0;
    tick();
    n_chk++; if ({inst_ack, inst_data} !== {1'b0, 32'h2008_0005}) begin n_err++; $display("FAIL fetch_hold got %b %h exp 0 20080005", inst_ack, inst_data); end
  endtask

  task automatic test_priority();
    inst_ren = 1'b1; inst_addr = 32'h100;
    mem_ren = 1'b1; mem_addr = 32'h40;
    tick();
    n_chk++; if ({bus_req, bus_we, bus_addr} !== {1'b1, 1'b0, 32'h40}) begin n_err++; $display("FAIL prio_data_first got %b%b %h exp 1 0 00000040", bus_req, bus_we, bus_addr); end
    tick();
    n_chk++; if ({mem_ack, inst_ack, mem_din} !== {2'b10, rdata_of(32'h40)}) begin n_err++; $display("FAIL prio_data_ack got %b%b %h exp 10 %h", mem_ack, inst_ack, mem_din, rdata_of(32'h40)); end
    n_chk++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL prio_stall_mid got %b exp 1", cpu_stall); end
    mem_ren = 1'b0;
    tick();
    n_chk++; if ({bus_req, cpu_stall} !== 2'b01) begin n_err++; $display("FAIL prio_idle got %b exp 01", {bus_req, cpu_stall}); end
    tick();
    n_chk++; if ({bus_req, bus_addr} !== {1'b1, 32'h100}) begin n_err++; $display("FAIL prio_inst_second got %b %h exp 1 00000100", bus_req, bus_addr); end
    tick();
    n_chk++; if ({inst_ack, inst_data, cpu_stall} !== {1'b1, rdata_of(32'h100), 1'b0}) begin n_err++; $display("FAIL prio_inst_ack got %b %h %b exp 1 %h 0", inst_ack, inst_data, cpu_stall, rdata_of(32'h100)); end
    inst_ren = 1'b0;
    tick();
  endtask

  task automatic test_write();
    mem_wen = 1'b1; mem_addr = 32'h44; mem_dout = 32'hDEAD_BEEF;
    tick();
    n_chk++; if ({bus_req, bus_we, bus_addr, bus_wdata} !== {2'b11, 32'h44, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL write_bus got %b%b %h %h exp 11 00000044 deadbeef", bus_req, bus_we, bus_addr, bus_wdata); end
    tick();
    n_chk++; if ({mem_ack, bus_err, mem_din} !== {2'b10, rdata_of(32'h40)}) begin n_err++; $display("FAIL write_ack got %b%b %h exp 10 %h", mem_ack, bus_err, mem_din, rdata_of(32'h40)); end
    mem_wen = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    mem_ren = 1'b1; mem_addr = 32'h42;
    tick();
    n_chk++; if ({bus_req, mem_ack, bus_err} !== 3'b011) begin n_err++; $display("FAIL misalign_flags got %b exp 011", {bus_req, mem_ack, bus_err}); end
    n_chk++; if (mem_din !== 32'h0) begin n_err++; $display("FAIL misalign_din got %h exp 00000000", mem_din); end
    mem_ren = 1'b0;
    tick();
    n_chk++; if ({bus_req, mem_ack, bus_err} !== 3'b000) begin n_err++; $display("FAIL misalign_after got %b exp 000", {bus_req, mem_ack, bus_err}); end
  endtask

  task automatic test_timeout();
    int n_req;
    int guard;
    mem_ren = 1'b1; mem_addr = 32'h84;
    repeat (2) tick();
    n_chk++; if ({mem_ack, mem_din} !== {1'b1, rdata_of(32'h84)}) begin n_err++; $display("FAIL tmo_preload got %b %h exp 1 %h", mem_ack, mem_din, rdata_of(32'h84)); end
    mem_ren = 1'b0;
    tick();
    auto_ack = 1'b0;
    mem_ren = 1'b1; mem_addr = 32'h80;
    tick();
    n_req = 0;
    guard = 0;
    while (mem_ack !== 1'b1 && guard < 200) begin
      if (bus_req === 1'b1) n_req++;
      tick();
      guard++;
    end
    n_chk++; if (guard >= 200) begin n_err++; $display("FAIL tmo_no_abort got no mem_ack within %0d cycles exp abort", guard); end
    n_chk++; if (n_req != 64) begin n_err++; $display("FAIL tmo_length got %0d bus_req cycles exp 64", n_req); end
    n_chk++; if ({mem_ack, bus_err, bus_req, mem_din} !== {3'b110, 32'h0}) begin n_err++; $display("FAIL tmo_abort got %b %h exp 110 00000000", {mem_ack, bus_err, bus_req}, mem_din); end
    mem_ren = 1'b0;
    auto_ack = 1'b1;
    tick();
    n_chk++; if ({bus_req, mem_ack, bus_err} !== 3'b000) begin n_err++; $display("FAIL tmo_idle got %b exp 000", {bus_req, mem_ack, bus_err}); end
    mem_ren = 1'b1; mem_addr = 32'h88;
    tick();
    n_chk++; if ({bus_req, bus_addr} !== {1'b1, 32'h88}) begin n_err++; $display("FAIL tmo_recover got %b %h exp 1 00000088", bus_req, bus_addr); end
    tick();
    mem_ren = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    int n_data;
    int guard;
    logic seen_inst;
    noack_addr = 32'h200;
    inst_ren = 1'b1; inst_addr = 32'h200;
    mem_ren = 1'b1; mem_addr = 32'h300;
    n_data = 0;
    guard = 0;
    seen_inst = 1'b0;
    while (!seen_inst && guard < 60) begin
      tick();
      guard++;
      if (bus_req === 1'b1 && bus_addr === 32'h300) n_data++;
      if (bus_req === 1'b1 && bus_addr === 32'h200) seen_inst = 1'b1;
    end
    n_chk++; if (!seen_inst) begin n_err++; $display("FAIL fair_no_inst got no inst grant in %0d cycles exp grant", guard); end
    n_chk++; if (n_data != 4) begin n_err++; $display("FAIL fair_count got %0d data grants exp 4", n_data); end
    n_chk++; if ({bus_we, cpu_stall} !== 2'b01) begin n_err++; $display("FAIL fair_inst_bus got %b exp 01", {bus_we, cpu_stall}); end
    cpu_rst_n = 1'b0;
    #1;
    n_chk++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL rst_mid_inst got %b exp 0", bus_req); end
    inst_ren = 1'b0; mem_ren = 1'b0;
    @(negedge clk);
    cpu_rst_n = 1'b1;
    noack_addr = 32'hFFFF_FFFF;
    tick();
    n_chk++; if ({bus_req, inst_ack, mem_ack, bus_addr} !== {3'b000, 32'h0}) begin n_err++; $display("FAIL rst_after got %b %h exp 000 00000000", {bus_req, inst_ack, mem_ack}, bus_addr); end
  endtask

  initial begin
    test_reset();
    test_inst_fetch();
    test_priority();
    test_write();
    test_misaligned();
    test_timeout();
    test_fairness();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
